// File: rtl/alu_divider_pkg.sv
// Shared definitions for the ALU divider: operation encodings, FSM states
// and a small helper for signedness of an operation.
package alu_divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_t;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   // DIV and REM are the signed operations; bit 0 selects unsigned.
   function automatic logic is_signed_op(input logic [1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/alu_divider_div_step.sv
// One restoring shift-subtract iteration: shifts the next dividend bit into
// the partial remainder and subtracts the divisor when the result stays non-negative.
module alu_divider_div_step
   import alu_divider_pkg::*;
#(
   parameter int N = 32
) (
   input  logic [N:0]   rem,
   input  logic         dividend_msb,
   input  logic [N-1:0] divisor,
   output logic [N:0]   rem_next,
   output logic         q_bit
);

   logic [N+1:0] shifted;
   logic [N+1:0] trial;

   // The partial remainder stays below the divisor, so the extra top bit
   // only serves as the sign of the trial subtraction.
   assign shifted  = {rem, dividend_msb};
   assign trial    = shifted - {2'b00, divisor};
   assign q_bit    = ~trial[N+1];
   assign rem_next = q_bit ? trial[N:0] : shifted[N:0];

endmodule

// File: rtl/alu_divider.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU with a start/busy/done
// handshake and a fixed latency of N+1 edges from the accepting edge to done.
module alu_divider
   import alu_divider_pkg::*;
#(
   parameter int OPERAND_LENGTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [OPERAND_LENGTH-1:0] opd1,
   input  logic [OPERAND_LENGTH-1:0] opd2,
   input  logic [1:0]                div_op_select,
   output logic                      busy,
   output logic                      done,
   output logic [OPERAND_LENGTH-1:0] div_result
);

   localparam int N  = OPERAND_LENGTH;
   localparam int CW = $clog2(N);

   div_state_t    state_reg, state_next;
   logic          accept;
   logic [CW-1:0] count_reg;
   logic [N:0]    rem_reg;
   logic [N-1:0]  dvd_reg;
   logic [N-1:0]  dsr_reg;
   logic [N-1:0]  result_reg;
   logic [N-1:0]  fix_value;
   logic [1:0]    op_reg;
   logic          neg_q_reg;
   logic          neg_r_reg;
   logic          sgn;
   logic [N:0]    rem_next;
   logic          q_bit;

   alu_divider_div_step #(.N(N)) u_step (
      .rem          (rem_reg),
      .dividend_msb (dvd_reg[N-1]),
      .divisor      (dsr_reg),
      .rem_next     (rem_next),
      .q_bit        (q_bit)
   );

   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = RUN;
            end
         end
         RUN:  if (count_reg == CW'(N - 1)) state_next = FIX;
         FIX:  state_next = DONE;
         DONE: begin
            accept     = start;
            state_next = start ? RUN : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Divide by zero leaves the quotient all ones, so DIV only needs the
   // negation suppressed; overflow falls out of the unsigned math untouched.
   always_comb begin
      fix_value = dvd_reg;
      case (op_reg)
         OP_DIV:  fix_value = (dsr_reg == '0) ? {N{1'b1}} : (neg_q_reg ? -dvd_reg : dvd_reg);
         OP_DIVU: fix_value = dvd_reg;
         OP_REM:  fix_value = neg_r_reg ? -rem_reg[N-1:0] : rem_reg[N-1:0];
         OP_REMU: fix_value = rem_reg[N-1:0];
         default: fix_value = dvd_reg;
      endcase
   end

   assign sgn = is_signed_op(div_op_select);

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg  <= '0;
         rem_reg    <= '0;
         dvd_reg    <= '0;
         dsr_reg    <= '0;
         result_reg <= '0;
         op_reg     <= OP_DIV;
         neg_q_reg  <= 1'b0;
         neg_r_reg  <= 1'b0;
      end else if (accept) begin
         op_reg    <= div_op_select;
         dvd_reg   <= (sgn && opd1[N-1]) ? -opd1 : opd1;
         dsr_reg   <= (sgn && opd2[N-1]) ? -opd2 : opd2;
         neg_r_reg <= sgn & opd1[N-1];
         neg_q_reg <= sgn & (opd1[N-1] ^ opd2[N-1]);
         rem_reg   <= '0;
         count_reg <= '0;
      end else if (state_reg == RUN) begin
         rem_reg   <= rem_next;
         dvd_reg   <= {dvd_reg[N-2:0], q_bit};
         count_reg <= count_reg + CW'(1);
      end else if (state_reg == FIX) begin
         result_reg <= fix_value;
      end
   end

   assign busy       = (state_reg == RUN) || (state_reg == FIX);
   assign done       = (state_reg == DONE);
   assign div_result = result_reg;

endmodule
